// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
// No logic of its own; the state encoding and byte order live here.
// Byte order is a single constant so the word assembly has one definition.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_LO,
        ST_HI,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

    // Frame is good when the mod-256 sum of every byte, checksum included, equals this
    localparam logic [7:0] CKSUM_GOOD = 8'h00;

    // Instructions arrive low byte first
    localparam bit LO_FIRST = 1'b1;

    // Build a 16-bit word from the two bytes in arrival order
    function automatic logic [15:0] assemble(input logic [7:0] first_byte,
                                             input logic [7:0] second_byte);
        return LO_FIRST ? {second_byte, first_byte} : {first_byte, second_byte};
    endfunction

endpackage

// File: rtl/byte_checksum.sv
// Purpose: 8-bit mod-256 running sum over accepted frame bytes.
// Latency: sum updates on the edge after add; zero looks ahead combinationally.
// Backpressure: none; adds only when the parent asserts add.
module byte_checksum
    import loader_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       add,
    input  logic [7:0] din,
    output logic       zero
);

    logic [7:0] acc;
    logic [7:0] next_sum;

    assign next_sum = acc + din;

    // zero answers "would the sum including the byte on din be good", so the
    // parent can decide on the checksum byte in the same cycle it is accepted
    assign zero = (next_sum == CKSUM_GOOD);

    // Accumulate accepted bytes; clear wins over add at load start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= 8'h00;
        end else if (clear) begin
            acc <= 8'h00;
        end else if (add) begin
            acc <= next_sum;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Purpose: receive a framed byte stream, write instruction memory, verify checksum, release CPU.
// Latency: write strobe and done/error are registered, one cycle after the causing byte.
// Backpressure: in_ready depends only on state; a low in_valid stalls with no state change.
module program_loader
    import loader_pkg::*;
#(
    parameter int INSTR_W = 9,
    parameter int ADDR_W  = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_reset,
    output logic               busy,
    output logic               done,
    output logic               error
);

    localparam int         DEPTH   = 2 ** ADDR_W;
    localparam logic [8:0] DEPTH_9 = 9'(DEPTH);

    state_t              state;
    logic [7:0]          lo_byte;
    logic [ADDR_W-1:0]   index;
    logic [ADDR_W-1:0]   last_idx;
    logic                xfer;
    logic                can_start;
    logic                count_ok;
    logic                cks_zero;

    assign in_ready  = (state == ST_COUNT) || (state == ST_LO) ||
                       (state == ST_HI)    || (state == ST_CHECK);
    assign xfer      = in_valid && in_ready;
    assign can_start = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
    assign count_ok  = (in_data != 8'h00) && ({1'b0, in_data} <= DEPTH_9);

    byte_checksum u_cksum (
        .clk   (clk),
        .reset (reset),
        .clear (can_start),
        .add   (xfer),
        .din   (in_data),
        .zero  (cks_zero)
    );

    // Load sequencer: frame parsing, write strobe generation and status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            lo_byte    <= 8'h00;
            index      <= '0;
            last_idx   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_reset  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (can_start) begin
                        state     <= ST_COUNT;
                        index     <= '0;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        busy      <= 1'b1;
                        cpu_reset <= 1'b1;
                    end
                end
                ST_COUNT: begin
                    if (xfer) begin
                        if (count_ok) begin
                            // N-1 fits in ADDR_W bits because N <= DEPTH
                            last_idx <= ADDR_W'(in_data - 8'd1);
                            state    <= ST_LO;
                        end else begin
                            state <= ST_ERROR;
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end
                ST_LO: begin
                    if (xfer) begin
                        lo_byte <= in_data;
                        state   <= ST_HI;
                    end
                end
                ST_HI: begin
                    if (xfer) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= index;
                        imem_wdata <= INSTR_W'(assemble(lo_byte, in_data));
                        index      <= index + 1'b1;
                        state      <= (index == last_idx) ? ST_CHECK : ST_LO;
                    end
                end
                ST_CHECK: begin
                    if (xfer) begin
                        busy <= 1'b0;
                        if (cks_zero) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= ST_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    localparam int INSTR_W = 9;
    localparam int ADDR_W  = 5;
    localparam int DEPTH   = 32;

    typedef logic [7:0] bq_t[$];

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               in_valid;
    logic [7:0]         in_data;
    logic               in_ready;
    logic               imem_we;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_wdata;
    logic               cpu_reset;
    logic               busy;
    logic               done;
    logic               error;

    int errors = 0;
    int checks = 0;
    int stall_pct = 0;
    logic prev_busy = 1'b0;

    logic [ADDR_W-1:0]  exp_addr_q[$];
    logic [INSTR_W-1:0] exp_data_q[$];
    logic [1:0]         exp_res_q[$];

    program_loader #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},   in_ready,   0);
        check({tag, "_imem_we"},    imem_we,    0);
        check({tag, "_imem_addr"},  imem_addr,  0);
        check({tag, "_imem_wdata"}, imem_wdata, 0);
        check({tag, "_cpu_reset"},  cpu_reset,  1);
        check({tag, "_busy"},       busy,       0);
        check({tag, "_done"},       done,       0);
        check({tag, "_error"},      error,      0);
    endtask

    // Monitor: pops expected writes on every strobe and expected results when busy falls
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_busy = 1'b0;
            end else begin
                if (imem_we) begin
                    if (exp_addr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write",
                                 imem_addr, imem_wdata);
                    end else begin
                        check("write_addr", imem_addr, exp_addr_q.pop_front());
                        check("write_data", imem_wdata, exp_data_q.pop_front());
                    end
                end
                if (prev_busy && !busy) begin
                    if (exp_res_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got done=%0b error=%0b expected none",
                                 done, error);
                    end else begin
                        check("result_done_error", {done, error}, exp_res_q.pop_front());
                    end
                end
                prev_busy = busy;
            end
        end
    end

    // Pulse start in IDLE/DONE/ERROR; optionally present a junk byte alongside it
    task automatic do_start(input bit junk);
        start    = 1'b1;
        in_valid = junk;
        in_data  = 8'h5A;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        check("busy_after_start", busy, 1);
        check("cpu_reset_after_start", cpu_reset, 1);
        check("done_after_start", done, 0);
        check("error_after_start", error, 0);
    endtask

    // Present one byte from a negedge; the byte is taken on the posedge where in_ready is high
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        while (stall_pct > 0 && $urandom_range(99, 0) < stall_pct) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready) begin
            @(negedge clk);
            waited++;
            if (waited > 40) begin
                checks++;
                errors++;
                $display("FAIL byte_timeout: in_ready stayed 0 expected 1 for byte %0h", b);
                in_valid = 1'b0;
                return;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Reference model: frame rules applied directly to the byte list
    task automatic run_frame(input bq_t f, input bit junk);
        int n = f[0];
        int accepted;
        int s = 0;
        bit good;
        logic [15:0] w;
        if (n == 0 || n > DEPTH) begin
            accepted = 1;
        end else begin
            accepted = 2 * n + 2;
            for (int i = 0; i < n; i++) begin
                w = {f[2*i+2], f[2*i+1]};
                exp_addr_q.push_back(ADDR_W'(i));
                exp_data_q.push_back(w[INSTR_W-1:0]);
            end
        end
        for (int i = 0; i < accepted; i++) s = (s + int'(f[i])) % 256;
        good = (accepted > 1) && (s == 0);
        exp_res_q.push_back({good, !good});
        do_start(junk);
        for (int i = 0; i < accepted; i++) send_byte(f[i]);
        check("final_done",      done,      good);
        check("final_error",     error,     !good);
        check("final_cpu_reset", cpu_reset, !good);
        check("final_busy",      busy,      0);
        check("final_in_ready",  in_ready,  0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t f;
        int n;
        int s;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #2;
        check_reset_values("reset");
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check_reset_values("idle");

        // Good load, with a junk byte offered alongside start
        run_frame('{8'h02, 8'h23, 8'h01, 8'hAB, 8'h00, 8'h2F}, 1'b1);
        // Bad checksum
        run_frame('{8'h02, 8'h23, 8'h01, 8'hAB, 8'h00, 8'h30}, 1'b0);
        // Illegal counts
        run_frame('{8'h00}, 1'b0);
        run_frame('{8'h21}, 1'b0);
        // Backpressure
        stall_pct = 50;
        run_frame('{8'h02, 8'h23, 8'h01, 8'hAB, 8'h00, 8'h2F}, 1'b0);
        stall_pct = 0;

        // Reset during HI of the second instruction
        exp_addr_q.push_back(5'd0);
        exp_data_q.push_back(9'h123);
        do_start(1'b0);
        send_byte(8'h02);
        send_byte(8'h23);
        send_byte(8'h01);
        send_byte(8'hAB);
        #2 reset = 1'b1;
        #1 check_reset_values("midload_reset");
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        check("writes_after_reset", exp_addr_q.size(), 0);
        @(negedge clk);
        run_frame('{8'h02, 8'h23, 8'h01, 8'hAB, 8'h00, 8'h2F}, 1'b0);
        // Reload after DONE
        run_frame('{8'h01, 8'hFF, 8'h01, 8'hFF}, 1'b0);

        // Full-depth load, last write at DEPTH-1
        f = {};
        f.push_back(8'(DEPTH));
        s = DEPTH;
        for (int i = 0; i < 2 * DEPTH; i++) begin
            f.push_back(8'(i * 7 + 3));
            s += (i * 7 + 3) % 256;
        end
        f.push_back(8'((256 - (s % 256)) % 256));
        run_frame(f, 1'b0);

        // Randomized frames, some with corrupted checksum, some with stalls
        for (int t = 0; t < 12; t++) begin
            f = {};
            n = (t % 3 == 0) ? $urandom_range(1, 3) : $urandom_range(1, DEPTH);
            f.push_back(8'(n));
            s = n;
            for (int i = 0; i < 2 * n; i++) begin
                f.push_back(8'($urandom_range(255, 0)));
                s += int'(f[i+1]);
            end
            s = (256 - (s % 256)) % 256;
            if (t % 4 == 3) s = (s + $urandom_range(1, 255)) % 256;
            f.push_back(8'(s));
            stall_pct = (t % 2 == 1) ? 40 : 0;
            run_frame(f, t[0]);
        end
        stall_pct = 0;

        repeat (5) @(negedge clk);
        check("writes_left",  exp_addr_q.size(), 0);
        check("results_left", exp_res_q.size(),  0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Hardware program loader for the 8-bit CPU. It holds the CPU in reset and accepts a framed byte stream over a valid/ready handshake. It writes the decoded instruction words into instruction memory, verifies an 8-bit checksum, and releases the CPU only after a good load. It sits between a host byte source (UART receiver or bench driver) and the CPU's instruction memory write port, so no program image has to be preloaded into memory.

## Interface
- `INSTR_W`, default 9: instruction word width; bits above `INSTR_W` in a received word are discarded.
- `ADDR_W`, default 5: instruction memory address width; `DEPTH = 2**ADDR_W`.
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: single-cycle request to begin a load. Honoured only in IDLE, DONE or ERROR.
- `in_valid`, in, 1: host byte valid.
- `in_data`, in, 8: host byte.
- `in_ready`, out, 1: loader accepts a byte. A transfer occurs when `in_valid && in_ready`.
- `imem_we`, out, 1: one-cycle instruction memory write strobe.
- `imem_addr`, out, ADDR_W: write address.
- `imem_wdata`, out, INSTR_W: write data.
- `cpu_reset`, out, 1: CPU reset, held high until a verified load completes.
- `busy`, out, 1: load in progress.
- `done`, out, 1: last load verified.
- `error`, out, 1: last load failed.

## Operation
- Frame format, in order:
  - Count byte N, with 1 ≤ N ≤ DEPTH.
  - N instructions, each sent as 2 bytes, low byte first.
  - One checksum byte. The frame is good when the 8-bit sum (mod 256) of all frame bytes, checksum included, is 0x00.
- FSM states: IDLE, COUNT, LO, HI, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR + `start`:
  - Go to COUNT.
  - Clear the accumulator, index, `done` and `error`.
  - Set `busy` and `cpu_reset`.
- COUNT, on transfer:
  - N = 0 or N > DEPTH → ERROR.
  - Otherwise latch N, add the byte to the accumulator, go to LO.
- LO, on transfer: latch the low byte, accumulate, go to HI.
- HI, on transfer:
  - Accumulate.
  - Register the write: `imem_wdata` = {hi, lo}[INSTR_W-1:0], `imem_addr` = index, `imem_we` = 1 for one cycle.
  - Increment the index.
  - Go to LO, or to CHECK if this was instruction N.
- CHECK, on transfer:
  - (acc + byte) mod 256 == 0 → DONE: `done` = 1, `cpu_reset` = 0, `busy` = 0.
  - Otherwise → ERROR: `error` = 1, `busy` = 0, `cpu_reset` stays 1.
- `in_ready` is 1 only in COUNT, LO, HI and CHECK. It is combinational from the state.
- `start` while `busy` is ignored. `start` in the same cycle as a transfer in IDLE does not consume the byte.
- Memory contents after ERROR are undefined. The CPU is never released on ERROR.
- A new `start` from DONE re-asserts `cpu_reset` the next cycle.

## Timing
- Reset values: `in_ready` 0, `imem_we` 0, `imem_addr` 0, `imem_wdata` 0, `cpu_reset` 1, `busy` 0, `done` 0, `error` 0, state IDLE.
- `reset` mid-load: immediately return to IDLE with reset values. No partial write strobe is issued after reset asserts.
- `busy` rises 1 cycle after `start`.
- Write strobe: `imem_we` is high exactly one cycle, in the cycle after the HI byte transfer.
- Release: `cpu_reset` falls and `done` rises one cycle after the checksum byte transfer.
- Throughput: one byte per cycle. A full load takes 2N+2 transfer cycles, plus a 1-cycle start latency.
- Stalls: `in_valid` low for any number of cycles stalls the loader with no state change.
- The index counter wraps only through the N ≤ DEPTH check. With N = DEPTH, the last write goes to address DEPTH-1.

## Structure
- Shared package `loader_pkg` holds:
  - The state enum.
  - `CKSUM_GOOD = 8'h00`.
  - The low/high byte order constant.
- One natural sub-module, `byte_checksum`: an 8-bit mod-256 accumulator with clear and add-enable inputs and a zero output.
- The rest is a single FSM with index and count registers.

## Test plan
- Good load: `start`; bytes 02, 23, 01, AB, 00, 2F → writes (0, 9'h123) and (1, 9'h0AB). `done` = 1 and `cpu_reset` = 0 one cycle after byte 2F.
- Bad checksum: the same frame with 30 as the last byte → `error` = 1, `cpu_reset` stays 1, `done` = 0.
- Illegal count: count byte 00, then count byte 21 with ADDR_W = 5 → ERROR immediately after the count byte, with no `imem_we`.
- Backpressure: the good-load frame with `in_valid` randomly deasserted → identical writes and result, and no byte is consumed twice.
- Reset during HI: assert `reset` after the second instruction's low byte → all outputs return to reset values. A subsequent clean frame loads correctly.
- Reload after DONE: `start` → `cpu_reset` = 1 the next cycle. A 1-instruction frame 01, FF, 01, FF (sum 0x200 → 0x00) → write (0, 9'h1FF) and release.
